// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect request and the
// decode-side valid/ready handshake. The fetch unit connects through the
// master modport; the memory/decode environment uses the slave modport.
interface fetch_unit_if #(
  parameter int N = 32,
  parameter int K = 512
);
  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic [AW-1:0] IramAddr;
  logic [N-1:0]  IramData;
  logic          RedirValid;
  logic [31:0]   RedirPc;
  logic          InstrValid;
  logic          InstrReady;
  logic [N-1:0]  Instr;
  logic [31:0]   InstrPc;

  modport master (
    output IramAddr,
    input  IramData,
    input  RedirValid,
    input  RedirPc,
    output InstrValid,
    input  InstrReady,
    output Instr,
    output InstrPc
  );

  modport slave (
    input  IramAddr,
    output IramData,
    output RedirValid,
    output RedirPc,
    input  InstrValid,
    output InstrReady,
    input  Instr,
    input  InstrPc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: two-stage (address issue / data capture) fetch
// pipeline in front of a synchronous instruction RAM with one-cycle read
// latency. A stalled output stage re-issues the in-flight address so the RAM
// output keeps presenting the in-flight word, which removes the need for a
// skid buffer. Redirects flush both stages and restart at the new target.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the 32-bit saturating StallCnt
// output counting cycles where a valid instruction waits on decode.
module fetch_unit #(
  parameter int          N        = 32,
  parameter int          K        = 512,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           Clk,
  input  logic           Rst,
  fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]    StallCnt
`endif
);

  localparam int AW = (K > 1) ? $clog2(K) : 1;

  // ifv lives in bit 0 of the state encoding: BOOT has nothing in flight,
  // RUN and HOLD both have a word in flight.
  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ifpc_q, ifpc_d;
  logic          instr_valid_q, instr_valid_d;
  logic [N-1:0]  instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;

  logic          ifv;
  logic          adv;
  logic [31:0]   fetch_addr;
  logic          unused_addr_bits;

  assign ifv = state_q[0];

  // The output stage may move whenever it is empty or being consumed.
  assign adv = !instr_valid_q || bus.InstrReady;

  // While stalled the in-flight address is re-issued so IramData stays put.
  assign fetch_addr       = adv ? pc_q : ifpc_q;
  assign bus.IramAddr     = fetch_addr[AW+1:2];
  assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0], bus.RedirPc[1:0]};

  assign bus.InstrValid = instr_valid_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrPc    = instr_pc_q;

  // FSM next state: redirect flushes to BOOT, otherwise RUN/HOLD track adv.
  always_comb begin
    state_d = state_q;
    if (bus.RedirValid) begin
      state_d = S_BOOT;
    end else begin
      case (state_q)
        S_BOOT:         if (adv) state_d = S_RUN;
        S_RUN, S_HOLD:  state_d = adv ? S_RUN : S_HOLD;
        default:        state_d = S_BOOT;
      endcase
    end
  end

  // Datapath next state: redirect beats advance, advance beats hold.
  always_comb begin
    pc_d          = pc_q;
    ifpc_d        = ifpc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    if (bus.RedirValid) begin
      pc_d          = {bus.RedirPc[31:2], 2'b00};
      instr_valid_d = 1'b0;
    end else if (adv) begin
      instr_valid_d = ifv;
      instr_d       = bus.IramData;
      instr_pc_d    = ifpc_q;
      ifpc_d        = pc_q;
      pc_d          = pc_q + 32'd4;
    end
  end

  // State and datapath registers, cleared asynchronously so a mid-stream
  // reset drops any held instruction immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      ifpc_q        <= 32'h0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifpc_q        <= ifpc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count decode back-pressure cycles; saturate instead of wrapping and
  // keep counting across redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (instr_valid_q && !bus.InstrReady && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule
